// File: rtl/regfile_2r1w_if.sv
// regfile_2r1w_if
// ---------------
// Bundles the write port, the bulk clear, both read ports and the occupancy
// output of the 2-read/1-write register file.
//   master : decode/control + writeback side (drives requests, reads results)
//   slave  : the register file itself
// Signals:
//   wr_en, wr_addr[AW], wr_data[WIDTH]    write request
//   clr                                   synchronous clear of all valid bits
//   rd_addr_a/b[AW]                       read addresses
//   rd_data_a/b[WIDTH], rd_valid_a/b      combinational read results
//   valid_count[AW+1]                     number of written entries
interface regfile_2r1w_if #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             clr;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_valid_a;
    logic             rd_valid_b;
    logic [AW:0]      valid_count;

    modport master (
        output wr_en, wr_addr, wr_data, clr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, valid_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, valid_count
    );
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w_rd
// ---------------
// One combinational read port: pending-write bypass first, then the array
// gated by the entry's valid bit. Anything else reads as zero, so neither
// unwritten entries nor out-of-range addresses ever leak X.
// Ports:
//   addr          read address
//   pend_v/addr/data  posted write waiting to commit
//   valid, mem    per-entry valid bits and storage
//   data, vld     read result
module regfile_2r1w_rd #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]               addr,
    input  logic                        pend_v,
    input  logic [AW-1:0]               pend_addr,
    input  logic [WIDTH-1:0]            pend_data,
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    output logic [WIDTH-1:0]            data,
    output logic                        vld
);
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic in_range;

    // With a power-of-two depth every address is legal; skip the compare.
    if (DEPTH == (1 << AW)) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_part
        assign in_range = ({1'b0, addr} < DEPTH_LIM);
    end

    always_comb begin
        data = '0;
        vld  = 1'b0;
        if (pend_v && (pend_addr == addr)) begin
            data = pend_data;
            vld  = 1'b1;
        end else if (in_range && valid[addr]) begin
            data = mem[addr];
            vld  = 1'b1;
        end
    end
endmodule

// regfile_2r1w
// ------------
// Parametrised 2-read/1-write register file. Writes are posted through a
// one-entry pending stage and commit into the array on the following edge;
// the read ports bypass the pending stage so a write is visible one cycle
// after its request. Per-entry valid bits, a synchronous bulk clear and an
// occupancy counter let the controller tell written entries from unwritten.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears pending, valid, count)
//   bus    regfile_2r1w_if.slave (write port, clr, read ports A/B, count)
module regfile_2r1w #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    regfile_2r1w_if.slave  bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          NUM_RD    = 2;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE       = (AW+1)'(1);

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } pend_t;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            valid;
    logic                        pend_v;
    pend_t                       pend;
    logic [AW:0]                 valid_count;
    logic                        wr_in_range;
    logic                        wr_ok;
    logic                        commit;

    if (DEPTH == (1 << AW)) begin : g_wr_full
        assign wr_in_range = 1'b1;
    end else begin : g_wr_part
        assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_LIM);
    end

    // Out-of-range requests never enter the pending stage, so pend.addr is
    // always a legal index below.
    assign wr_ok  = bus.wr_en && wr_in_range;
    // A clear discards whatever was pending instead of committing it.
    assign commit = pend_v && !bus.clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v      <= 1'b0;
            pend        <= '0;
            valid       <= '0;
            valid_count <= '0;
        end else begin
            pend_v <= wr_ok;
            if (wr_ok) begin
                pend.addr <= bus.wr_addr;
                pend.data <= bus.wr_data;
            end
            if (bus.clr) begin
                valid       <= '0;
                valid_count <= '0;
            end else if (commit) begin
                valid[pend.addr] <= 1'b1;
                // Only a first write to an entry grows the occupancy.
                if (!valid[pend.addr]) begin
                    valid_count <= valid_count + ONE;
                end
            end
        end
    end

    // Storage is deliberately not reset; the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[pend.addr] <= pend.data;
        end
    end

    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_valid;

    assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_2r1w_rd #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rd (
            .addr      (rd_addr[i]),
            .pend_v    (pend_v),
            .pend_addr (pend.addr),
            .pend_data (pend.data),
            .valid     (valid),
            .mem       (mem),
            .data      (rd_data[i]),
            .vld       (rd_valid[i])
        );
    end

    assign bus.rd_data_a   = rd_data[0];
    assign bus.rd_data_b   = rd_data[1];
    assign bus.rd_valid_a  = rd_valid[0];
    assign bus.rd_valid_b  = rd_valid[1];
    assign bus.valid_count = valid_count;
endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;
    localparam int W = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_2r1w_if #(.WIDTH(W), .DEPTH(16)) bus16();
    regfile_2r1w_if #(.WIDTH(W), .DEPTH(12)) bus12();

    regfile_2r1w #(.WIDTH(W), .DEPTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    regfile_2r1w #(.WIDTH(W), .DEPTH(12)) dut12 (.clk(clk), .reset(reset), .bus(bus12));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the 16-entry instance: what has been written and
    // what is still waiting to land.
    logic [W-1:0] m_data [16];
    bit           m_valid[16];
    bit           m_pv;
    int           m_pa;
    logic [W-1:0] m_pd;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_pv = 1'b0;
    endtask

    task automatic model_edge();
        if (bus16.clr) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (m_pv) begin
            m_data[m_pa]  = m_pd;
            m_valid[m_pa] = 1'b1;
        end
        m_pv = bus16.wr_en;
        if (m_pv) begin
            m_pa = int'(bus16.wr_addr);
            m_pd = bus16.wr_data;
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic void model_read(input int a, output logic [W-1:0] d, output bit v);
        d = '0;
        v = 1'b0;
        if (m_pv && m_pa == a) begin
            d = m_pd; v = 1'b1;
        end else if (m_valid[a]) begin
            d = m_data[a]; v = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle16();
        bus16.wr_en = 1'b0;
        bus16.clr   = 1'b0;
    endtask

    task automatic wr16(input int a, input logic [W-1:0] d);
        bus16.wr_en   = 1'b1;
        bus16.wr_addr = 4'(a);
        bus16.wr_data = d;
    endtask

    task automatic clear16();
        bus16.wr_en = 1'b0;
        bus16.clr   = 1'b1;
        tick();
        bus16.clr   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus16.valid_count !== 5'd0) begin n_fail++; $display("FAIL reset_cnt16: got %0d want 0", bus16.valid_count); end
        n_checks++; if (bus16.rd_valid_a !== 1'b0 || bus16.rd_data_a !== '0) begin n_fail++; $display("FAIL reset_rd16: got %h/%b want 0/0", bus16.rd_data_a, bus16.rd_valid_a); end
        n_checks++; if (bus12.valid_count !== 5'd0 || bus12.rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_12: got cnt %0d vb %b want 0/0", bus12.valid_count, bus12.rd_valid_b); end
        @(negedge clk);
        reset = 1'b1;
        // Commit one entry and leave a second one pending, then reset mid-stream.
        wr16(4, 20'h04444); tick();
        wr16(6, 20'h06666); tick();
        idle16();
        bus16.rd_addr_a = 4'd4;
        bus16.rd_addr_b = 4'd6;
        #1;
        n_checks++; if (bus16.valid_count !== 5'd1 || bus16.rd_data_b !== 20'h06666) begin n_fail++; $display("FAIL pre_reset: got cnt %0d db %h want 1/06666", bus16.valid_count, bus16.rd_data_b); end
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if (bus16.valid_count !== 5'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d want 0", bus16.valid_count); end
        n_checks++; if (bus16.rd_valid_a !== 1'b0 || bus16.rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL async_reset_vld: got %b/%b want 0/0", bus16.rd_valid_a, bus16.rd_valid_b); end
        n_checks++; if (bus16.rd_data_a !== '0 || bus16.rd_data_b !== '0) begin n_fail++; $display("FAIL async_reset_data: got %h/%h want 0/0", bus16.rd_data_a, bus16.rd_data_b); end
        @(negedge clk);
        reset = 1'b1;
        bus16.rd_addr_a = 4'd3;
        tick();
        n_checks++; if (bus16.rd_data_a !== '0 || bus16.rd_valid_a !== 1'b0 || bus16.rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL post_reset_rd: got %h/%b vb %b want 0/0/0", bus16.rd_data_a, bus16.rd_valid_a, bus16.rd_valid_b); end
    endtask

    task automatic test_write_bypass();
        clear16();
        wr16(5, 20'h0ABCD); tick();
        idle16();
        bus16.rd_addr_a = 4'd5;
        bus16.rd_addr_b = 4'd1;
        #1;
        n_checks++; if (bus16.rd_data_a !== 20'h0ABCD || bus16.rd_valid_a !== 1'b1) begin n_fail++; $display("FAIL bypass_rd: got %h/%b want 0abcd/1", bus16.rd_data_a, bus16.rd_valid_a); end
        n_checks++; if (bus16.valid_count !== 5'd0) begin n_fail++; $display("FAIL bypass_cnt: got %0d want 0", bus16.valid_count); end
        tick();
        bus16.rd_addr_b = 4'd5;
        #1;
        n_checks++; if (bus16.valid_count !== 5'd1) begin n_fail++; $display("FAIL commit_cnt: got %0d want 1", bus16.valid_count); end
        n_checks++; if (bus16.rd_data_b !== 20'h0ABCD || bus16.rd_valid_b !== 1'b1) begin n_fail++; $display("FAIL commit_rd: got %h/%b want 0abcd/1", bus16.rd_data_b, bus16.rd_valid_b); end
    endtask

    task automatic test_back_to_back();
        clear16();
        wr16(2, 20'h11111); tick();
        wr16(2, 20'h22222); tick();
        idle16();
        bus16.rd_addr_a = 4'd2;
        #1;
        n_checks++; if (bus16.rd_data_a !== 20'h22222 || bus16.rd_valid_a !== 1'b1) begin n_fail++; $display("FAIL b2b_rd: got %h/%b want 22222/1", bus16.rd_data_a, bus16.rd_valid_a); end
        tick();
        bus16.rd_addr_b = 4'd2;
        #1;
        n_checks++; if (bus16.valid_count !== 5'd1) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 1", bus16.valid_count); end
        n_checks++; if (bus16.rd_data_b !== 20'h22222) begin n_fail++; $display("FAIL b2b_rd_b: got %h want 22222", bus16.rd_data_b); end
    endtask

    task automatic test_fill_overwrite();
        clear16();
        for (int a = 0; a < 16; a++) begin
            wr16(a, W'(a * 3)); tick();
        end
        idle16(); tick();
        n_checks++; if (bus16.valid_count !== 5'd16) begin n_fail++; $display("FAIL fill_cnt: got %0d want 16", bus16.valid_count); end
        for (int a = 0; a < 16; a++) begin
            bus16.rd_addr_a = 4'(a);
            bus16.rd_addr_b = 4'(15 - a);
            #1;
            n_checks++;
            if (bus16.rd_data_a !== W'(a * 3) || bus16.rd_valid_a !== 1'b1 || bus16.rd_data_b !== W'((15 - a) * 3)) begin
                n_fail++;
                $display("FAIL fill_rd[%0d]: got %h/%b b %h want %h/1 b %h", a, bus16.rd_data_a, bus16.rd_valid_a, bus16.rd_data_b, W'(a * 3), W'((15 - a) * 3));
            end
        end
        wr16(0, 20'h0005A); tick();
        idle16(); tick();
        bus16.rd_addr_a = 4'd0;
        #1;
        n_checks++; if (bus16.valid_count !== 5'd16) begin n_fail++; $display("FAIL overwrite_cnt: got %0d want 16", bus16.valid_count); end
        n_checks++; if (bus16.rd_data_a !== 20'h0005A) begin n_fail++; $display("FAIL overwrite_rd: got %h want 0005a", bus16.rd_data_a); end
    endtask

    task automatic test_clear_concurrent();
        clear16();
        wr16(7, 20'h00077); tick();
        bus16.clr = 1'b1;
        wr16(9, 20'h00099); tick();
        idle16();
        bus16.rd_addr_a = 4'd7;
        bus16.rd_addr_b = 4'd9;
        #1;
        n_checks++; if (bus16.rd_data_a !== '0 || bus16.rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL clr_discard: got %h/%b want 0/0", bus16.rd_data_a, bus16.rd_valid_a); end
        n_checks++; if (bus16.rd_data_b !== 20'h00099 || bus16.rd_valid_b !== 1'b1) begin n_fail++; $display("FAIL clr_wr_bypass: got %h/%b want 00099/1", bus16.rd_data_b, bus16.rd_valid_b); end
        n_checks++; if (bus16.valid_count !== 5'd0) begin n_fail++; $display("FAIL clr_cnt0: got %0d want 0", bus16.valid_count); end
        tick();
        n_checks++; if (bus16.valid_count !== 5'd1 || bus16.rd_data_b !== 20'h00099 || bus16.rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL clr_cnt1: got cnt %0d db %h va %b want 1/00099/0", bus16.valid_count, bus16.rd_data_b, bus16.rd_valid_a); end
    endtask

    task automatic test_out_of_range();
        bus12.clr = 1'b1; tick();
        bus12.clr = 1'b0;
        bus12.wr_en = 1'b1; bus12.wr_addr = 4'd1; bus12.wr_data = 20'h00111; tick();
        bus12.wr_en = 1'b0; tick();
        n_checks++; if (bus12.valid_count !== 5'd1) begin n_fail++; $display("FAIL oor_base_cnt: got %0d want 1", bus12.valid_count); end
        bus12.wr_en = 1'b1; bus12.wr_addr = 4'd13; bus12.wr_data = 20'h0DEAD; tick();
        bus12.wr_en = 1'b0;
        bus12.rd_addr_a = 4'd13;
        bus12.rd_addr_b = 4'd1;
        #1;
        n_checks++; if (bus12.rd_data_a !== '0 || bus12.rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL oor_bypass: got %h/%b want 0/0", bus12.rd_data_a, bus12.rd_valid_a); end
        n_checks++; if (bus12.rd_data_b !== 20'h00111 || bus12.rd_valid_b !== 1'b1) begin n_fail++; $display("FAIL oor_other: got %h/%b want 00111/1", bus12.rd_data_b, bus12.rd_valid_b); end
        tick();
        n_checks++; if (bus12.valid_count !== 5'd1 || bus12.rd_valid_a !== 1'b0 || bus12.rd_data_a !== '0) begin n_fail++; $display("FAIL oor_after: got cnt %0d %h/%b want 1/0/0", bus12.valid_count, bus12.rd_data_a, bus12.rd_valid_a); end
        bus12.rd_addr_a = 4'd12;
        #1;
        n_checks++; if (bus12.rd_data_a !== '0 || bus12.rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL oor_rd12: got %h/%b want 0/0", bus12.rd_data_a, bus12.rd_valid_a); end
    endtask

    task automatic test_random();
        logic [W-1:0] ed;
        bit           ev;
        int           ra, rb;
        clear16();
        for (int c = 0; c < 400; c++) begin
            bus16.wr_en   = ($urandom_range(0, 3) != 0);
            bus16.wr_addr = 4'($urandom_range(0, 15));
            bus16.wr_data = W'($urandom);
            bus16.clr     = ($urandom_range(0, 24) == 0);
            tick();
            ra = int'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 15));
            // Half the time aim port A at whatever is pending, to hit the bypass.
            if (m_pv && $urandom_range(0, 1) == 1) ra = m_pa;
            bus16.rd_addr_a = 4'(ra);
            bus16.rd_addr_b = 4'(rb);
            #1;
            model_read(ra, ed, ev);
            n_checks++; if (bus16.rd_data_a !== ed || bus16.rd_valid_a !== ev) begin n_fail++; $display("FAIL rnd_a[%0d] addr %0d: got %h/%b want %h/%b", c, ra, bus16.rd_data_a, bus16.rd_valid_a, ed, ev); end
            model_read(rb, ed, ev);
            n_checks++; if (bus16.rd_data_b !== ed || bus16.rd_valid_b !== ev) begin n_fail++; $display("FAIL rnd_b[%0d] addr %0d: got %h/%b want %h/%b", c, rb, bus16.rd_data_b, bus16.rd_valid_b, ed, ev); end
            n_checks++; if (int'(bus16.valid_count) != model_cnt()) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, bus16.valid_count, model_cnt()); end
        end
        idle16();
    endtask

    initial begin
        bus16.wr_en = 1'b0; bus16.wr_addr = '0; bus16.wr_data = '0; bus16.clr = 1'b0;
        bus16.rd_addr_a = '0; bus16.rd_addr_b = '0;
        bus12.wr_en = 1'b0; bus12.wr_addr = '0; bus12.wr_data = '0; bus12.clr = 1'b0;
        bus12.rd_addr_a = '0; bus12.rd_addr_b = '0;
        model_reset();
        test_reset();
        test_write_bypass();
        test_back_to_back();
        test_fill_overwrite();
        test_clear_concurrent();
        test_out_of_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised two-read/one-write register file: the next generation of the processor's single-port register store. Writes are posted through a one-entry pending stage, and forwarding makes them visible on both read ports one cycle after the request. Per-entry valid bits, a synchronous bulk clear and an occupancy counter let the control unit tell unwritten registers from written ones. It sits between the decode/control unit (read ports A/B for the two operands) and the ALU writeback path (write port).

## Interface
- WIDTH, 20, data word width in bits
- DEPTH, 16, number of entries, 2..256, need not be a power of two
- AW, $clog2(DEPTH), address width (localparam, derived)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting clears all state immediately
- wr_en  in  1  write request, sampled at clk rising edge
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- clr  in  1  synchronous clear of all valid bits
- rd_addr_a  in  AW  read port A address
- rd_addr_b  in  AW  read port B address
- rd_data_a  out  WIDTH  port A data, combinational
- rd_data_b  out  WIDTH  port B data, combinational
- rd_valid_a  out  1  port A entry holds written data
- rd_valid_b  out  1  port B entry holds written data
- valid_count  out  AW+1  number of valid entries, 0..DEPTH

## Operation
- State:
  - array mem[DEPTH] of WIDTH; data is not reset
  - valid[DEPTH] bits
  - pending stage: pend_v, pend_addr, pend_data
  - valid_count register
- Write pipeline:
  - Edge with wr_en=1 and wr_addr<DEPTH: load pend_* with the request and set pend_v=1.
  - Edge with wr_en=0: pend_v=0.
  - Every edge with pend_v=1: mem[pend_addr] takes pend_data and valid[pend_addr] is set, in parallel with loading any new request.
- Out-of-range write (wr_addr>=DEPTH): dropped, with no pend_v and no count change.
- Read, per port independently, evaluated each cycle:
  - If pend_v and pend_addr==rd_addr: data=pend_data, valid=1 (bypass).
  - Else if rd_addr<DEPTH and valid[rd_addr]: data=mem[rd_addr], valid=1.
  - Else: data=0, valid=0. Unwritten or out-of-range entries never expose X.
- Both ports may read the same address in the same cycle; results are identical.
- valid_count increments by 1 on a commit into an entry whose valid bit is 0. A commit into an already-valid entry does not change it. It never exceeds DEPTH.
- clr=1 at an edge:
  - Clears every valid bit, sets valid_count=0 and discards the existing pending write (no commit).
  - A concurrent wr_en is still captured into the pending stage and commits on the following edge. Clear-then-write ordering applies.
- Back-to-back writes to the same address: the previous one commits while the new one enters pending. Reads show the newest value. valid_count increments once.

## Timing
- Reset (reset=0, asynchronous), immediately and held until release:
  - pend_v=0, all valid=0, valid_count=0
  - rd_data_a/b=0, rd_valid_a/b=0
- First edge after reset release: normal operation, with no dead cycle.
- Write visibility latency: request at edge N appears on the read ports after edge N (same cycle as pend_v). It reaches the array at edge N+1.
- Read latency: 0 cycles, combinational from rd_addr and state.
- valid_count updates at the commit edge (N+1), not at the request edge.
- No backpressure: wr_en is accepted every cycle, with sustained throughput of 1 write per cycle.

## Test plan
- Reset: drive reset=0 mid-stream with pend_v=1 -> immediately valid_count=0, rd_valid_a/b=0, rd_data=0. After release, read addr 3 -> data 0, valid 0.
- Write/bypass: wr_en at edge N, addr 5, data 0x0ABCD. In the cycle after edge N, rd_addr_a=5 -> 0x0ABCD valid 1, valid_count still 0. After edge N+1, valid_count=1 and rd_addr_b=5 -> 0x0ABCD.
- Back-to-back: write addr 2 with 0x11111 then 0x22222 on consecutive edges -> reads show 0x22222 after the second edge, valid_count=1 after both commits.
- Fill and overwrite: write all 16 addresses with data=addr*3 -> valid_count=16, every read matches. Rewrite addr 0 -> count stays 16.
- Clear with concurrent write: pending write to addr 7 (0x00077); assert clr and wr_en (addr 9, 0x00099) at the same edge. Result: addr 7 reads 0 valid 0, addr 9 reads 0x00099, and valid_count=1 after the next edge.
- Out of range: with DEPTH=12, write addr 13 -> no state change, valid_count unchanged, read addr 13 -> 0 valid 0.
